axi4_burst_sram: RTL and testbench

//  Parametrised AXI4 slave memory model for NPC simulation. It sits behind cpu_top's io_master port in place of the fixed SRAM.

---
 rtl/axi4_burst_sram.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi4_burst_sram.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_sram.sv
// AXI4 slave memory model with INCR/FIXED/WRAP bursts, programmable read/write latency,
// independent read and write channels and OKAY/SLVERR/DECERR responses.
module axi4_burst_sram #(
   parameter int                ADDR_W      = 32,
   parameter int                ID_W        = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
   parameter int                DEPTH_WORDS = 65536,
   parameter int                RD_LAT      = 2,
   parameter int                WR_LAT      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_slave_awvalid,
   output logic              io_slave_awready,
   input  logic [ADDR_W-1:0] io_slave_awaddr,
   input  logic [ID_W-1:0]   io_slave_awid,
   input  logic [7:0]        io_slave_awlen,
   input  logic [2:0]        io_slave_awsize,
   input  logic [1:0]        io_slave_awburst,
   input  logic              io_slave_wvalid,
   output logic              io_slave_wready,
   input  logic [31:0]       io_slave_wdata,
   input  logic [3:0]        io_slave_wstrb,
   input  logic              io_slave_wlast,
   output logic              io_slave_bvalid,
   input  logic              io_slave_bready,
   output logic [1:0]        io_slave_bresp,
   output logic [ID_W-1:0]   io_slave_bid,
   input  logic              io_slave_arvalid,
   output logic              io_slave_arready,
   input  logic [ADDR_W-1:0] io_slave_araddr,
   input  logic [ID_W-1:0]   io_slave_arid,
   input  logic [7:0]        io_slave_arlen,
   input  logic [2:0]        io_slave_arsize,
   input  logic [1:0]        io_slave_arburst,
   output logic              io_slave_rvalid,
   input  logic              io_slave_rready,
   output logic [31:0]       io_slave_rdata,
   output logic [1:0]        io_slave_rresp,
   output logic              io_slave_rlast,
   output logic [ID_W-1:0]   io_slave_rid
);
   localparam int              IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] SPAN      = (ADDR_W+1)'(4 * DEPTH_WORDS);
   localparam logic [15:0]     RD_LAT_M1 = 16'(RD_LAT - 1);
   localparam logic [15:0]     WR_LAT_M1 = 16'(WR_LAT - 1);
   localparam logic [1:0]      RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                   input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_W-1:0] step, inc, wmask, res;
      step  = ADDR_W'(1) << size;
      inc   = (a & ~(step - ADDR_W'(1))) + step;
      wmask = (ADDR_W'(len) + ADDR_W'(1)) * step - ADDR_W'(1);
      case (burst)
         2'b00:   res = a;
         2'b10:   res = (a & ~wmask) | (inc & wmask);
         default: res = inc;
      endcase
      return res;
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a >= BASE_ADDR) && (off < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   function automatic logic bad_burst(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      return (size > 3'd2) || (burst == 2'b11) ||
             (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
   endfunction

   // Response codes are ordered so that the numerically larger one is the worse one.
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] mem_rd_reg;
   logic        ready_en_reg;

   // ---------------- read channel ----------------
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} r_state_t;
   r_state_t          r_state_reg, r_state_next;
   logic [ADDR_W-1:0] r_addr_reg, r_load_addr;
   logic [7:0]        r_len_reg, r_beat_reg, r_load_beat;
   logic [2:0]        r_size_reg;
   logic [1:0]        r_burst_reg, rresp_reg;
   logic [ID_W-1:0]   r_id_reg;
   logic [15:0]       r_cnt_reg;
   logic              r_bad_reg, rlast_reg, r_sel_reg, ar_hs, r_hs, r_load;

   assign ar_hs = io_slave_arvalid && io_slave_arready;
   assign r_hs  = io_slave_rvalid && io_slave_rready;

   always_comb begin
      r_state_next = r_state_reg;
      r_load       = 1'b0;
      r_load_addr  = r_addr_reg;
      r_load_beat  = 8'd0;
      case (r_state_reg)
         R_IDLE: if (ar_hs) r_state_next = R_WAIT;
         R_WAIT: if (r_cnt_reg == '0) begin
            r_state_next = R_BEAT;
            r_load       = 1'b1;
         end
         R_BEAT: if (r_hs) begin
            if (rlast_reg) begin
               r_state_next = R_IDLE;
            end else begin
               r_load      = 1'b1;
               r_load_addr = next_addr(r_addr_reg, r_len_reg, r_size_reg, r_burst_reg);
               r_load_beat = r_beat_reg + 8'd1;
            end
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state_reg <= R_IDLE;
         ready_en_reg <= 1'b0;
         r_addr_reg <= '0; r_len_reg <= '0; r_beat_reg <= '0; r_size_reg <= '0;
         r_burst_reg <= '0; r_id_reg <= '0; r_cnt_reg <= '0; r_bad_reg <= 1'b0;
         rresp_reg <= RESP_OKAY; rlast_reg <= 1'b0; r_sel_reg <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
         r_state_reg  <= r_state_next;
         if (ar_hs) begin
            r_addr_reg  <= io_slave_araddr;
            r_len_reg   <= io_slave_arlen;
            r_size_reg  <= io_slave_arsize;
            r_burst_reg <= io_slave_arburst;
            r_id_reg    <= io_slave_arid;
            r_bad_reg   <= bad_burst(io_slave_arlen, io_slave_arsize, io_slave_arburst);
            r_cnt_reg   <= RD_LAT_M1;
            r_beat_reg  <= 8'd0;
         end else if (r_state_reg == R_WAIT && r_cnt_reg != '0) begin
            r_cnt_reg <= r_cnt_reg - 16'd1;
         end
         if (r_load) begin
            r_addr_reg <= r_load_addr;
            r_beat_reg <= r_load_beat;
            rlast_reg  <= (r_load_beat == r_len_reg);
            r_sel_reg  <= in_range(r_load_addr) && !r_bad_reg;
            rresp_reg  <= !in_range(r_load_addr) ? RESP_DECERR : (r_bad_reg ? RESP_SLVERR : RESP_OKAY);
         end
      end
   end

   // ---------------- write channel ----------------
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
   w_state_t          w_state_reg, w_state_next;
   logic [ADDR_W-1:0] w_addr_reg;
   logic [7:0]        w_len_reg;
   logic [8:0]        w_beat_reg;
   logic [2:0]        w_size_reg;
   logic [1:0]        w_burst_reg, bresp_reg, w_beat_resp;
   logic [ID_W-1:0]   bid_reg;
   logic [15:0]       w_cnt_reg;
   logic              w_bad_reg, aw_hs, w_hs, b_hs, w_beat_in, wr_en;

   assign aw_hs     = io_slave_awvalid && io_slave_awready;
   assign w_hs      = io_slave_wvalid && io_slave_wready;
   assign b_hs      = io_slave_bvalid && io_slave_bready;
   assign w_beat_in = (w_beat_reg <= {1'b0, w_len_reg});

   always_comb begin
      w_state_next = w_state_reg;
      wr_en        = 1'b0;
      w_beat_resp  = RESP_OKAY;
      if (w_beat_in) begin
         if (!in_range(w_addr_reg)) w_beat_resp = RESP_DECERR;
         else if (w_bad_reg)        w_beat_resp = RESP_SLVERR;
      end
      if (io_slave_wlast && w_beat_reg != {1'b0, w_len_reg})
         w_beat_resp = worst(w_beat_resp, RESP_SLVERR);
      case (w_state_reg)
         W_IDLE: if (aw_hs) w_state_next = W_DATA;
         W_DATA: if (w_hs) begin
            wr_en = w_beat_in && in_range(w_addr_reg) && !w_bad_reg;
            if (io_slave_wlast) w_state_next = W_WAIT;
         end
         W_WAIT: if (w_cnt_reg == '0) w_state_next = W_RESP;
         W_RESP: if (b_hs) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state_reg <= W_IDLE;
         w_addr_reg <= '0; w_len_reg <= '0; w_beat_reg <= '0; w_size_reg <= '0;
         w_burst_reg <= '0; w_bad_reg <= 1'b0; w_cnt_reg <= '0;
         bresp_reg <= RESP_OKAY; bid_reg <= '0;
      end else begin
         w_state_reg <= w_state_next;
         if (aw_hs) begin
            w_addr_reg  <= io_slave_awaddr;
            w_len_reg   <= io_slave_awlen;
            w_size_reg  <= io_slave_awsize;
            w_burst_reg <= io_slave_awburst;
            w_bad_reg   <= bad_burst(io_slave_awlen, io_slave_awsize, io_slave_awburst);
            bid_reg     <= io_slave_awid;
            bresp_reg   <= RESP_OKAY;
            w_beat_reg  <= 9'd0;
         end
         if (w_hs) begin
            bresp_reg  <= worst(bresp_reg, w_beat_resp);
            w_addr_reg <= next_addr(w_addr_reg, w_len_reg, w_size_reg, w_burst_reg);
            if (w_beat_reg != '1) w_beat_reg <= w_beat_reg + 9'd1;
            if (io_slave_wlast) w_cnt_reg <= WR_LAT_M1;
         end else if (w_state_reg == W_WAIT && w_cnt_reg != '0) begin
            w_cnt_reg <= w_cnt_reg - 16'd1;
         end
      end
   end

   // Storage is never reset; a read in the same cycle as a write to that word sees the old data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (io_slave_wstrb[b]) mem[word_idx(w_addr_reg)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
      end
      if (r_load) mem_rd_reg <= mem[word_idx(r_load_addr)];
   end

   assign io_slave_arready = ready_en_reg && (r_state_reg == R_IDLE);
   assign io_slave_rvalid  = (r_state_reg == R_BEAT);
   assign io_slave_rdata   = r_sel_reg ? mem_rd_reg : 32'd0;
   assign io_slave_rresp   = rresp_reg;
   assign io_slave_rlast   = rlast_reg;
   assign io_slave_rid     = r_id_reg;
   assign io_slave_awready = ready_en_reg && (w_state_reg == W_IDLE);
   assign io_slave_wready  = (w_state_reg == W_DATA);
   assign io_slave_bvalid  = (w_state_reg == W_RESP);
   assign io_slave_bresp   = bresp_reg;
   assign io_slave_bid     = bid_reg;
endmodule

// File: tb/tb_axi4_burst_sram.sv
// Directed bench for axi4_burst_sram: bursts, latency, error responses, concurrency, reset.
module tb_axi4_burst_sram;
   logic        clk = 1'b0, reset = 1'b1;
   logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
   logic        arvalid = 0, arready, rvalid, rready = 0, rlast;
   logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
   logic [3:0]  awid = 0, arid = 0, bid, rid, wstrb = 0;
   logic [7:0]  awlen = 0, arlen = 0;
   logic [2:0]  awsize = 0, arsize = 0;
   logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;
   int checks = 0, fails = 0;

   always #5 clk = ~clk;

   axi4_burst_sram dut (
      .clk(clk), .reset(reset),
      .io_slave_awvalid(awvalid), .io_slave_awready(awready), .io_slave_awaddr(awaddr),
      .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize), .io_slave_awburst(awburst),
      .io_slave_wvalid(wvalid), .io_slave_wready(wready), .io_slave_wdata(wdata),
      .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
      .io_slave_bvalid(bvalid), .io_slave_bready(bready), .io_slave_bresp(bresp), .io_slave_bid(bid),
      .io_slave_arvalid(arvalid), .io_slave_arready(arready), .io_slave_araddr(araddr),
      .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize), .io_slave_arburst(arburst),
      .io_slave_rvalid(rvalid), .io_slave_rready(rready), .io_slave_rdata(rdata),
      .io_slave_rresp(rresp), .io_slave_rlast(rlast), .io_slave_rid(rid)
   );

   // Drivers: start and end on a falling edge; handshakes complete on the following rising edge.
   task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output bit ok);
      ok = 0; arvalid = 1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
      for (int i = 0; i < 50; i++) begin
         if (arready) begin ok = 1; break; end
         @(negedge clk);
      end
      @(posedge clk); @(negedge clk); arvalid = 0;
      $display("AR addr=%h id=%0d len=%0d burst=%0d", a, id, len, burst);
   endtask

   task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output bit ok);
      ok = 0; awvalid = 1; awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst;
      for (int i = 0; i < 50; i++) begin
         if (awready) begin ok = 1; break; end
         @(negedge clk);
      end
      @(posedge clk); @(negedge clk); awvalid = 0;
      $display("AW addr=%h id=%0d len=%0d burst=%0d", a, id, len, burst);
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok);
      ok = 0; wvalid = 1; wdata = d; wstrb = s; wlast = l;
      for (int i = 0; i < 50; i++) begin
         if (wready) begin ok = 1; break; end
         @(negedge clk);
      end
      @(posedge clk); @(negedge clk); wvalid = 0; wlast = 0;
      $display("W  data=%h strb=%h last=%0d", d, s, l);
   endtask

   task automatic r_recv(output logic [31:0] d, output logic [1:0] resp, output logic last,
                         output logic [3:0] id, output bit ok);
      ok = 0; rready = 1;
      for (int i = 0; i < 50; i++) begin
         if (rvalid) begin ok = 1; break; end
         @(negedge clk);
      end
      d = rdata; resp = rresp; last = rlast; id = rid;
      @(posedge clk); @(negedge clk); rready = 0;
      $display("R  data=%h resp=%0d last=%0d id=%0d", d, resp, last, id);
   endtask

   task automatic b_recv(output logic [1:0] resp, output logic [3:0] id, output bit ok);
      ok = 0; bready = 1;
      for (int i = 0; i < 50; i++) begin
         if (bvalid) begin ok = 1; break; end
         @(negedge clk);
      end
      resp = bresp; id = bid;
      @(posedge clk); @(negedge clk); bready = 0;
      $display("B  resp=%0d id=%0d", resp, id);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({rvalid, bvalid, wready, arready, awready} !== 5'b0 || rdata !== 32'd0 || rresp !== 2'd0 ||
          bresp !== 2'd0 || rid !== 4'd0 || bid !== 4'd0) begin
         fails++; $display("FAIL reset_outputs: got valid/ready=%b rdata=%h rresp=%0d bresp=%0d rid=%0d bid=%0d required all 0",
                           {rvalid, bvalid, wready, arready, awready}, rdata, rresp, bresp, rid, bid);
      end
      reset = 0;
      #1 checks++;
      if ({arready, awready} !== 2'b00) begin
         fails++; $display("FAIL reset_release_early: got ar/awready=%b required 00", {arready, awready});
      end
      @(negedge clk); checks++;
      if ({arready, awready} !== 2'b11) begin
         fails++; $display("FAIL reset_release_ready: got ar/awready=%b required 11", {arready, awready});
      end
   endtask

   task automatic test_single();
      bit ok; logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int n;
      aw_send(32'h8000_0000, 4'd9, 8'd0, 3'd2, 2'b01, ok);
      w_send(32'hDEADBEEF, 4'hF, 1'b1, ok);
      checks++;
      if (bvalid !== 1'b0) begin fails++; $display("FAIL t1_b_early: got bvalid=%b required 0", bvalid); end
      @(negedge clk); checks++;
      if (bvalid !== 1'b1) begin fails++; $display("FAIL t1_b_latency: got bvalid=%b required 1", bvalid); end
      b_recv(resp, id, ok); checks++;
      if (!ok || resp !== 2'd0 || id !== 4'd9) begin
         fails++; $display("FAIL t1_bresp: got ok=%0d resp=%0d id=%0d required 1 0 9", ok, resp, id);
      end
      ar_send(32'h8000_0000, 4'd6, 8'd0, 3'd2, 2'b01, ok);
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n != 2) begin fails++; $display("FAIL t1_rd_latency: got %0d cycles required 2", n); end
      r_recv(d, resp, last, id, ok); checks++;
      if (!ok || d !== 32'hDEADBEEF || resp !== 2'd0 || last !== 1'b1 || id !== 4'd6) begin
         fails++; $display("FAIL t1_read: got ok=%0d data=%h resp=%0d last=%0d id=%0d required 1 deadbeef 0 1 6",
                           ok, d, resp, last, id);
      end
   endtask

   task automatic test_incr();
      bit ok; logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
      logic [31:0] wd [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
      logic [3:0]  ws [4] = '{4'hF, 4'hF, 4'h3, 4'hF};
      logic [31:0] exp [4] = '{32'd1, 32'd2, 32'hCAFE0003, 32'd4};
      aw_send(32'h8000_0018, 4'd1, 8'd0, 3'd2, 2'b01, ok);
      w_send(32'hCAFE1234, 4'hF, 1'b1, ok);
      b_recv(resp, id, ok);
      aw_send(32'h8000_0010, 4'd2, 8'd3, 3'd2, 2'b01, ok);
      for (int i = 0; i < 4; i++) w_send(wd[i], ws[i], i == 3, ok);
      b_recv(resp, id, ok); checks++;
      if (!ok || resp !== 2'd0 || id !== 4'd2) begin
         fails++; $display("FAIL t2_bresp: got ok=%0d resp=%0d id=%0d required 1 0 2", ok, resp, id);
      end
      ar_send(32'h8000_0010, 4'd2, 8'd3, 3'd2, 2'b01, ok);
      for (int i = 0; i < 4; i++) begin
         r_recv(d, resp, last, id, ok); checks++;
         if (!ok || d !== exp[i] || resp !== 2'd0 || last !== (i == 3)) begin
            fails++; $display("FAIL t2_beat%0d: got ok=%0d data=%h resp=%0d last=%0d required data=%h resp=0 last=%0d",
                              i, ok, d, resp, last, exp[i], i == 3);
         end
      end
   endtask

   task automatic test_wrap_fixed();
      bit ok; logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
      logic [31:0] exp [4] = '{32'hCAFE0003, 32'd4, 32'd1, 32'd2};
      ar_send(32'h8000_0018, 4'd4, 8'd3, 3'd2, 2'b10, ok);
      for (int i = 0; i < 4; i++) begin
         r_recv(d, resp, last, id, ok); checks++;
         if (!ok || d !== exp[i] || resp !== 2'd0 || last !== (i == 3) || id !== 4'd4) begin
            fails++; $display("FAIL t3_wrap_beat%0d: got ok=%0d data=%h resp=%0d last=%0d id=%0d required %h 0 %0d 4",
                              i, ok, d, resp, last, id, exp[i], i == 3);
         end
      end
      ar_send(32'h8000_0014, 4'd5, 8'd1, 3'd2, 2'b00, ok);
      for (int i = 0; i < 2; i++) begin
         r_recv(d, resp, last, id, ok); checks++;
         if (!ok || d !== 32'd2 || resp !== 2'd0 || last !== (i == 1)) begin
            fails++; $display("FAIL t3_fixed_beat%0d: got ok=%0d data=%h resp=%0d last=%0d required 2 0 %0d",
                              i, ok, d, resp, last, i == 1);
         end
      end
   endtask

   task automatic test_errors();
      bit ok; logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
      ar_send(32'h7FFF_FFFC, 4'd3, 8'd0, 3'd2, 2'b01, ok);
      r_recv(d, resp, last, id, ok); checks++;
      if (!ok || d !== 32'd0 || resp !== 2'b11 || last !== 1'b1) begin
         fails++; $display("FAIL t4_decerr_read: got ok=%0d data=%h resp=%0d last=%0d required 0 3 1", ok, d, resp, last);
      end
      ar_send(32'h8000_0010, 4'd3, 8'd2, 3'd2, 2'b10, ok);
      for (int i = 0; i < 3; i++) begin
         r_recv(d, resp, last, id, ok); checks++;
         if (!ok || d !== 32'd0 || resp !== 2'b10 || last !== (i == 2)) begin
            fails++; $display("FAIL t4_slverr_beat%0d: got ok=%0d data=%h resp=%0d last=%0d required 0 2 %0d",
                              i, ok, d, resp, last, i == 2);
         end
      end
      aw_send(32'h8000_0060, 4'd7, 8'd1, 3'd2, 2'b01, ok);
      w_send(32'h77, 4'hF, 1'b1, ok);
      b_recv(resp, id, ok); checks++;
      if (!ok || resp !== 2'b10 || id !== 4'd7) begin
         fails++; $display("FAIL t4_short_write: got ok=%0d resp=%0d id=%0d required 1 2 7", ok, resp, id);
      end
      aw_send(32'h7FFF_FFF0, 4'd1, 8'd0, 3'd2, 2'b01, ok);
      w_send(32'h99, 4'hF, 1'b1, ok);
      b_recv(resp, id, ok); checks++;
      if (!ok || resp !== 2'b11) begin
         fails++; $display("FAIL t4_decerr_write: got ok=%0d resp=%0d required 1 3", ok, resp);
      end
   endtask

   task automatic test_concurrent();
      bit ok, ok2, bgot, bhold, rhold; int beat;
      logic [1:0] hb, hr; logic [3:0] hid; logic [31:0] hd; logic hl;
      logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
      logic [31:0] exp [4] = '{32'd1, 32'd2, 32'hCAFE0003, 32'd4};
      arvalid = 1; araddr = 32'h8000_0010; arid = 4'd3; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
      awvalid = 1; awaddr = 32'h8000_0040; awid = 4'd8; awlen = 8'd1; awsize = 3'd2; awburst = 2'b01;
      checks++;
      if ({arready, awready} !== 2'b11) begin
         fails++; $display("FAIL t5_both_ready: got %b required 11", {arready, awready});
      end
      @(posedge clk); @(negedge clk); arvalid = 0; awvalid = 0;
      bgot = 0; bhold = 0; rhold = 0; beat = 0;
      fork
         begin
            w_send(32'h11, 4'hF, 1'b0, ok);
            w_send(32'h22, 4'hF, 1'b1, ok);
            for (int c = 0; c < 100 && !bgot; c++) begin
               if (bhold) begin
                  checks++;
                  if (!bvalid || bresp !== hb || bid !== hid) begin
                     fails++; $display("FAIL t5_b_stable: got bvalid=%b resp=%0d id=%0d required 1 %0d %0d", bvalid, bresp, bid, hb, hid);
                  end
               end
               bhold = 0;
               if (bvalid) begin
                  bready = 1'($urandom_range(0, 1));
                  if (bready) begin
                     bgot = 1; checks++;
                     if (bresp !== 2'd0 || bid !== 4'd8) begin
                        fails++; $display("FAIL t5_bresp: got resp=%0d id=%0d required 0 8", bresp, bid);
                     end
                     $display("B  resp=%0d id=%0d", bresp, bid);
                  end else begin
                     bhold = 1; hb = bresp; hid = bid;
                  end
               end else bready = 0;
               @(posedge clk); @(negedge clk);
            end
            bready = 0; checks++;
            if (!bgot) begin fails++; $display("FAIL t5_b_timeout: got no response required 1"); end
         end
         begin
            for (int c = 0; c < 200 && beat < 4; c++) begin
               if (rhold) begin
                  checks++;
                  if (!rvalid || rdata !== hd || rresp !== hr || rlast !== hl) begin
                     fails++; $display("FAIL t5_r_stable: got rvalid=%b data=%h resp=%0d last=%0d required 1 %h %0d %0d",
                                       rvalid, rdata, rresp, rlast, hd, hr, hl);
                  end
               end
               rhold = 0;
               if (rvalid) begin
                  rready = 1'($urandom_range(0, 1));
                  if (rready) begin
                     checks++;
                     if (rdata !== exp[beat] || rresp !== 2'd0 || rlast !== (beat == 3) || rid !== 4'd3) begin
                        fails++; $display("FAIL t5_beat%0d: got data=%h resp=%0d last=%0d id=%0d required %h 0 %0d 3",
                                          beat, rdata, rresp, rlast, rid, exp[beat], beat == 3);
                     end
                     $display("R  data=%h resp=%0d last=%0d id=%0d", rdata, rresp, rlast, rid);
                     beat++;
                  end else begin
                     rhold = 1; hd = rdata; hr = rresp; hl = rlast;
                  end
               end else rready = 0;
               @(posedge clk); @(negedge clk);
            end
            rready = 0; checks++;
            if (beat != 4) begin fails++; $display("FAIL t5_r_timeout: got %0d beats required 4", beat); end
         end
      join
      ar_send(32'h8000_0040, 4'd0, 8'd1, 3'd2, 2'b01, ok2);
      for (int i = 0; i < 2; i++) begin
         r_recv(d, resp, last, id, ok2); checks++;
         if (!ok2 || d !== ((i == 0) ? 32'h11 : 32'h22)) begin
            fails++; $display("FAIL t5_readback%0d: got ok=%0d data=%h required %h", i, ok2, d, (i == 0) ? 32'h11 : 32'h22);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok; int n; logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
      ar_send(32'h8000_0010, 4'd2, 8'd3, 3'd2, 2'b01, ok);
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      aw_send(32'h8000_0050, 4'd2, 8'd3, 3'd2, 2'b01, ok);
      w_send(32'h55, 4'hF, 1'b0, ok);
      w_send(32'h66, 4'hF, 1'b0, ok);
      checks++;
      if ({rvalid, wready} !== 2'b11) begin
         fails++; $display("FAIL t6_pre_reset: got rvalid/wready=%b required 11", {rvalid, wready});
      end
      reset = 1;
      #1 checks++;
      if ({rvalid, bvalid, wready, arready, awready} !== 5'b0 || rdata !== 32'd0) begin
         fails++; $display("FAIL t6_in_reset: got valid/ready=%b rdata=%h required 00000 0",
                           {rvalid, bvalid, wready, arready, awready}, rdata);
      end
      @(negedge clk); @(negedge clk); reset = 0;
      @(negedge clk); checks++;
      if ({arready, awready} !== 2'b11 || {rvalid, bvalid, wready} !== 3'b0) begin
         fails++; $display("FAIL t6_after_reset: got ar/awready=%b valids/wready=%b required 11 000",
                           {arready, awready}, {rvalid, bvalid, wready});
      end
      ar_send(32'h8000_0050, 4'd1, 8'd1, 3'd2, 2'b01, ok);
      for (int i = 0; i < 2; i++) begin
         r_recv(d, resp, last, id, ok); checks++;
         if (!ok || d !== ((i == 0) ? 32'h55 : 32'h66) || resp !== 2'd0) begin
            fails++; $display("FAIL t6_committed%0d: got ok=%0d data=%h resp=%0d required %h 0",
                              i, ok, d, resp, (i == 0) ? 32'h55 : 32'h66);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_incr();
      test_wrap_fixed();
      test_errors();
      test_concurrent();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
